// File: rtl/alu_ctrl_stage_pkg.sv
// Shared ALU control encodings and MIPS opcode/funct constants,
// used by both the ALU and the ID/EX control stage.
package alu_ctrl_stage_pkg;

    localparam int IO_BUS_WIDTH  = 32;
    localparam int CTR_BUS_WIDTH = 4;

    localparam logic [3:0] CTR_SLL   = 4'd0;
    localparam logic [3:0] CTR_SRL   = 4'd1;
    localparam logic [3:0] CTR_SRA   = 4'd2;
    localparam logic [3:0] CTR_ADD   = 4'd3;
    localparam logic [3:0] CTR_SUB   = 4'd4;
    localparam logic [3:0] CTR_AND   = 4'd5;
    localparam logic [3:0] CTR_OR    = 4'd6;
    localparam logic [3:0] CTR_XOR   = 4'd7;
    localparam logic [3:0] CTR_NOR   = 4'd8;
    localparam logic [3:0] CTR_SLT   = 4'd9;
    localparam logic [3:0] CTR_SLLV  = 4'd10;
    localparam logic [3:0] CTR_SRLV  = 4'd11;
    localparam logic [3:0] CTR_SRAV  = 4'd12;
    localparam logic [3:0] CTR_SLL16 = 4'd13;
    localparam logic [3:0] CTR_NEQ   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS opcode/funct -> ALU ctr_code and operand-source decode.
// Unsupported encodings fall back to ADD with illegal raised.
module alu_ctrl_decode
    import alu_ctrl_stage_pkg::*;
#(
    parameter int CTR_BUS_WIDTH = 4,
    parameter int OP_WIDTH      = 6
) (
    input  logic [OP_WIDTH-1:0]      opcode,
    input  logic [OP_WIDTH-1:0]      funct,
    output logic [CTR_BUS_WIDTH-1:0] ctr_code,
    output logic                     src_b_shamt,
    output logic                     src_b_imm,
    output logic                     illegal
);

    logic [3:0] code;

    always_comb begin
        code        = CTR_ADD;
        src_b_shamt = 1'b0;
        src_b_imm   = 1'b0;
        illegal     = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FUNCT_SLL:  begin code = CTR_SLL; src_b_shamt = 1'b1; end
                FUNCT_SRL:  begin code = CTR_SRL; src_b_shamt = 1'b1; end
                FUNCT_SRA:  begin code = CTR_SRA; src_b_shamt = 1'b1; end
                FUNCT_SLLV: code = CTR_SLLV;
                FUNCT_SRLV: code = CTR_SRLV;
                FUNCT_SRAV: code = CTR_SRAV;
                FUNCT_ADD, FUNCT_ADDU, FUNCT_JR, FUNCT_JALR: code = CTR_ADD;
                FUNCT_SUB, FUNCT_SUBU: code = CTR_SUB;
                FUNCT_AND:  code = CTR_AND;
                FUNCT_OR:   code = CTR_OR;
                FUNCT_XOR:  code = CTR_XOR;
                FUNCT_NOR:  code = CTR_NOR;
                FUNCT_SLT:  code = CTR_SLT;
                default:    illegal = 1'b1;
            endcase
        end else if (opcode[5:4] == 2'b10) begin
            // loads and stores: address = base + offset
            code      = CTR_ADD;
            src_b_imm = 1'b1;
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU, OP_J, OP_JAL: begin code = CTR_ADD; src_b_imm = 1'b1; end
                OP_SLTI: begin code = CTR_SLT;   src_b_imm = 1'b1; end
                OP_ANDI: begin code = CTR_AND;   src_b_imm = 1'b1; end
                OP_ORI:  begin code = CTR_OR;    src_b_imm = 1'b1; end
                OP_XORI: begin code = CTR_XOR;   src_b_imm = 1'b1; end
                OP_LUI:  begin code = CTR_SLL16; src_b_imm = 1'b1; end
                OP_BEQ, OP_BNE: code = CTR_NEQ;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign ctr_code = CTR_BUS_WIDTH'(code);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage at ID/EX with a 2-entry skid buffer.
// Optional saturating illegal counter: define ALU_CTRL_ILLEGAL_CNT_EN.
module alu_ctrl_stage
    import alu_ctrl_stage_pkg::*;
#(
    parameter int CTR_BUS_WIDTH = 4,
    parameter int OP_WIDTH      = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_WIDTH-1:0]      opcode,
    input  logic [OP_WIDTH-1:0]      funct,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTR_BUS_WIDTH-1:0] ctr_code,
    output logic                     src_b_shamt,
    output logic                     src_b_imm,
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    output logic [15:0]              illegal_count,
`endif
    output logic                     illegal
);

    localparam int EW = CTR_BUS_WIDTH + 3;

    logic [CTR_BUS_WIDTH-1:0] dec_ctr;
    logic                     dec_shamt, dec_imm, dec_illegal;

    alu_ctrl_decode #(
        .CTR_BUS_WIDTH (CTR_BUS_WIDTH),
        .OP_WIDTH      (OP_WIDTH)
    ) u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .ctr_code    (dec_ctr),
        .src_b_shamt (dec_shamt),
        .src_b_imm   (dec_imm),
        .illegal     (dec_illegal)
    );

    logic [EW-1:0] dec_entry, out_q, skid_q;
    logic          out_valid_q, skid_valid_q;
    logic          accept, out_free;

    assign dec_entry = {dec_ctr, dec_shamt, dec_imm, dec_illegal};
    // in_ready comes straight from the skid flop, isolating decode from out_ready
    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready && !flush;
    assign out_free  = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec_entry;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign {ctr_code, src_b_shamt, src_b_imm, illegal} = out_q;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            illegal_cnt_q <= '0;
        else if (accept && dec_illegal && illegal_cnt_q != 16'hFFFF)
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end

    assign illegal_count = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] opcode, funct;
    logic [3:0] ctr_code;
    logic       src_b_shamt, src_b_imm, illegal;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [15:0] illegal_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_ctrl_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ctr_code    (ctr_code),
        .src_b_shamt (src_b_shamt),
        .src_b_imm   (src_b_imm),
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        .illegal_count (illegal_count),
`endif
        .illegal     (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct = '0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        opcode = 6'b000000; funct = 6'b100001;
        repeat (3) step();
        total++;
        if (out_valid !== 1'b0 || ctr_code !== 4'd0 || src_b_shamt !== 1'b0 ||
            src_b_imm !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b ctr=%0d sh=%b imm=%b ill=%b, want all 0",
                     out_valid, ctr_code, src_b_shamt, src_b_imm, illegal);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode_sweep();
        // {opcode, funct, ctr, shamt, imm, illegal}
        logic [5:0] op_t  [12] = '{6'b000000, 6'b001111, 6'b000101, 6'b000000, 6'b000000, 6'b000000,
                                   6'b000000, 6'b100011, 6'b000000, 6'b000000, 6'b001010, 6'b000010};
        logic [5:0] fn_t  [12] = '{6'b000011, 6'b000000, 6'b000000, 6'b000100, 6'b100111, 6'b101010,
                                   6'b001000, 6'b000000, 6'b000001, 6'b100011, 6'b000000, 6'b000000};
        logic [3:0] ctr_t [12] = '{4'd2, 4'd13, 4'd14, 4'd10, 4'd8, 4'd9, 4'd3, 4'd3, 4'd3, 4'd4, 4'd9, 4'd3};
        logic [2:0] fl_t  [12] = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                                   3'b000, 3'b010, 3'b001, 3'b000, 3'b010, 3'b010};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; opcode = op_t[i]; funct = fn_t[i];
            step();
            total++;
            if (out_valid !== 1'b1 || ctr_code !== ctr_t[i] ||
                {src_b_shamt, src_b_imm, illegal} !== fl_t[i]) begin
                bad++;
                $display("FAIL decode_%0d: got v=%b ctr=%0d flags=%b, want v=1 ctr=%0d flags=%b",
                         i, out_valid, ctr_code, {src_b_shamt, src_b_imm, illegal}, ctr_t[i], fl_t[i]);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL decode_drain: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] exp_seq [2] = '{4'd5, 4'd6};
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; opcode = 6'b000000;
        funct = 6'b100001;
        step();
        total++;
        if (out_valid !== 1'b1 || ctr_code !== 4'd3 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_first: got v=%b ctr=%0d rdy=%b, want v=1 ctr=3 rdy=1", out_valid, ctr_code, in_ready);
        end
        funct = 6'b100100;
        step();
        total++;
        if (out_valid !== 1'b1 || ctr_code !== 4'd3 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_skid_fill: got v=%b ctr=%0d rdy=%b, want v=1 ctr=3 rdy=0", out_valid, ctr_code, in_ready);
        end
        funct = 6'b100101;
        step();
        total++;
        if (out_valid !== 1'b1 || ctr_code !== 4'd3 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: got v=%b ctr=%0d rdy=%b, want v=1 ctr=3 rdy=0", out_valid, ctr_code, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || ctr_code !== exp_seq[i] || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL bp_drain_%0d: got v=%b ctr=%0d rdy=%b, want v=1 ctr=%0d rdy=1",
                         i, out_valid, ctr_code, in_ready, exp_seq[i]);
            end
            if (i == 0) in_valid = 1'b1;
            else        in_valid = 1'b0;
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_dup: got v=%b ctr=%0d, want v=0", out_valid, ctr_code);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; opcode = 6'b000000;
        funct = 6'b100001; step();
        funct = 6'b100110; step();
        flush = 1'b1; funct = 6'b100100;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_full: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
        // flush with an empty stage and in_ready=1 must still drop the input
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_drop_%0d: got v=%b ctr=%0d, want v=0", i, out_valid, ctr_code);
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; opcode = 6'b111111; funct = 6'b000000;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || ctr_code !== 4'd3 ||
            src_b_shamt !== 1'b0 || src_b_imm !== 1'b0) begin
            bad++;
            $display("FAIL illegal_op: got v=%b ill=%b ctr=%0d sh=%b imm=%b, want 1 1 3 0 0",
                     out_valid, illegal, ctr_code, src_b_shamt, src_b_imm);
        end
        step();
    endtask

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    task automatic test_illegal_count();
        do_reset();
        out_ready = 1'b1; opcode = 6'b111111; funct = 6'b000000;
        total++;
        if (illegal_count !== 16'd0) begin
            bad++;
            $display("FAIL cnt_reset: got %0d, want 0", illegal_count);
        end
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (illegal_count !== 16'd3) begin
            bad++;
            $display("FAIL cnt_three: got %0d, want 3", illegal_count);
        end
        force dut.illegal_cnt_q = 16'hFFFF;
        #1;
        release dut.illegal_cnt_q;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (illegal_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL cnt_saturate: got %h, want ffff", illegal_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decode_sweep();
        test_back_pressure();
        test_flush();
        test_illegal();
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        test_illegal_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
